win_check_ctrl: RTL

Sequencer that runs after each accepted move and decides whether that move completed a five-in-a-row. It sits between the game control FSM and the board memory. On a start pulse it walks the board RAM read port along four directions from the placed stone, counting consecutive same-colour stones, and reports done/win. It is the only board-read master while busy.

---
 rtl/gobang_pkg.sv | 22 ++
 rtl/win_check_ctrl_if.sv | 12 +
 rtl/win_step_gen.sv | 54 +++++
 rtl/win_check_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/gobang_pkg.sv
// rtl/gobang_pkg.sv - shared cell codes, direction and state encodings for the win checker
package gobang_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [1:0] {
        DIR_H = 2'd0,
        DIR_V = 2'd1,
        DIR_D = 2'd2,
        DIR_A = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/win_check_ctrl_if.sv
// rtl/win_check_ctrl_if.sv - board RAM read port between the win checker and board memory
interface win_check_ctrl_if #(
    parameter int COORD_W = 4
);
    logic               rd_en;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [1:0]         rd_data;

    modport master (output rd_en, rd_x, rd_y, input rd_data);
    modport slave  (input rd_en, rd_x, rd_y, output rd_data);
endinterface

// File: rtl/win_step_gen.sv
// rtl/win_step_gen.sv - candidate cell = anchor + step*direction*side, with board bounds flag
module win_step_gen
    import gobang_pkg::*;
#(
    parameter int BOARD_W = 16,
    parameter int COORD_W = 4,
    parameter int STEP_W  = 4
) (
    input  logic [COORD_W-1:0] i_anchor_x,
    input  logic [COORD_W-1:0] i_anchor_y,
    input  dir_e               i_dir,
    input  logic               i_side,
    input  logic [STEP_W-1:0]  i_step,
    output logic [COORD_W-1:0] o_cand_x,
    output logic [COORD_W-1:0] o_cand_y,
    output logic               o_in_bounds
);
    localparam int SW = COORD_W + 1;
    localparam logic signed [SW-1:0] MAX_C = SW'(BOARD_W - 1);

    logic signed [SW-1:0] w_step_s;
    logic signed [SW-1:0] w_off_x;
    logic signed [SW-1:0] w_off_y;
    logic signed [SW-1:0] w_cx;
    logic signed [SW-1:0] w_cy;

    assign w_step_s = SW'(i_step);

    // Offsets along the vector; side '-' (i_side=1) mirrors both axes.
    always_comb begin
        w_off_x = '0;
        w_off_y = '0;
        case (i_dir)
            DIR_H: begin w_off_x = w_step_s;  w_off_y = '0;        end
            DIR_V: begin w_off_x = '0;        w_off_y = w_step_s;  end
            DIR_D: begin w_off_x = w_step_s;  w_off_y = w_step_s;  end
            DIR_A: begin w_off_x = w_step_s;  w_off_y = -w_step_s; end
            default: begin w_off_x = '0;      w_off_y = '0;        end
        endcase
        if (i_side) begin
            w_off_x = -w_off_x;
            w_off_y = -w_off_y;
        end
    end

    assign w_cx = $signed({1'b0, i_anchor_x}) + w_off_x;
    assign w_cy = $signed({1'b0, i_anchor_y}) + w_off_y;

    assign o_cand_x    = w_cx[COORD_W-1:0];
    assign o_cand_y    = w_cy[COORD_W-1:0];
    assign o_in_bounds = !w_cx[SW-1] && (w_cx <= MAX_C) &&
                         !w_cy[SW-1] && (w_cy <= MAX_C);

endmodule

// File: rtl/win_check_ctrl.sv
// rtl/win_check_ctrl.sv - walks the board from the last move in four directions to detect a winning run
module win_check_ctrl
    import gobang_pkg::*;
#(
    parameter int BOARD_W = 16,
    parameter int COORD_W = 4,
    parameter int WIN_LEN = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [1:0]         player,
    output logic               busy,
    output logic               done,
    output logic               win,
    win_check_ctrl_if.master   rd_bus
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

    state_e             r_state;
    state_e             w_next;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [1:0]         r_player;
    dir_e               r_dir;
    logic               r_side;
    logic [CNT_W-1:0]   r_step;
    logic [CNT_W-1:0]   r_count;
    logic               r_win;

    logic [COORD_W-1:0] w_cand_x;
    logic [COORD_W-1:0] w_cand_y;
    logic               w_in_bounds;
    logic               w_rd_en;
    logic               w_adv;
    logic               w_hit;
    logic               w_win_set;
    logic               w_last;
    logic               w_bad_player;
    logic               w_match;

    win_step_gen #(
        .BOARD_W (BOARD_W),
        .COORD_W (COORD_W),
        .STEP_W  (CNT_W)
    ) u_step_gen (
        .i_anchor_x  (r_x),
        .i_anchor_y  (r_y),
        .i_dir       (r_dir),
        .i_side      (r_side),
        .i_step      (r_step),
        .o_cand_x    (w_cand_x),
        .o_cand_y    (w_cand_y),
        .o_in_bounds (w_in_bounds)
    );

    assign w_last       = (r_dir == DIR_A) && r_side;
    assign w_bad_player = (r_player[0] == r_player[1]);
    assign w_match      = (rd_bus.rd_data == r_player);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_rd_en   = 1'b0;
        w_adv     = 1'b0;
        w_hit     = 1'b0;
        w_win_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_bad_player) begin
                    w_next = ST_DONE;
                end else if (w_in_bounds && (r_step <= LAST_CNT)) begin
                    w_rd_en = 1'b1;
                    w_next  = ST_EVAL;
                end else begin
                    // Off-board or run already long enough on this side: skip without a read.
                    w_adv  = 1'b1;
                    w_next = w_last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_EVAL: begin
                if (w_match) begin
                    w_hit = 1'b1;
                    if (r_count == LAST_CNT) begin
                        w_win_set = 1'b1;
                        w_next    = ST_DONE;
                    end else begin
                        w_next = ST_ISSUE;
                    end
                end else begin
                    w_adv  = 1'b1;
                    w_next = w_last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x      <= '0;
            r_y      <= '0;
            r_player <= CELL_EMPTY;
            r_dir    <= DIR_H;
            r_side   <= 1'b0;
            r_step   <= '0;
            r_count  <= '0;
            r_win    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_x      <= x_in;
                r_y      <= y_in;
                r_player <= player;
                r_dir    <= DIR_H;
                r_side   <= 1'b0;
                r_step   <= CNT_W'(1);
                r_count  <= CNT_W'(1);
                r_win    <= 1'b0;
            end
        end else if (w_adv) begin
            // Count carries across the two sides of one line, restarts per direction.
            r_step <= CNT_W'(1);
            if (!r_side) begin
                r_side <= 1'b1;
            end else begin
                r_side  <= 1'b0;
                r_dir   <= dir_e'(r_dir + 2'd1);
                r_count <= CNT_W'(1);
            end
        end else if (w_hit) begin
            r_count <= r_count + CNT_W'(1);
            if (w_win_set) r_win  <= 1'b1;
            else           r_step <= r_step + CNT_W'(1);
        end
    end

    assign rd_bus.rd_en = w_rd_en;
    assign rd_bus.rd_x  = w_rd_en ? w_cand_x : '0;
    assign rd_bus.rd_y  = w_rd_en ? w_cand_y : '0;
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign win          = r_win;

endmodule
